// File: rtl/phrase_packer.sv
// phrase_packer
//   Collects WORD_W-bit words from a valid/ready stream into phrases of
//   PHRASE_WORDS words for the memory write interface. A phrase closes when
//   it fills, when a word arrives with last_in, or on a flush_in request
//   while a partial phrase is pending. Partial phrases carry a keep mask.
//   There are two storage stages: an accumulator and an output register.
//   With both of them, a continuous stream is accepted at one word per cycle.
//
// Parameters
//   WORD_W        bits per input word
//   PHRASE_WORDS  words per phrase (power of two, >= 2)
//   MSW_FIRST     1: first-arriving word in the MS slot of data_out
//                 0: first-arriving word in data_out[WORD_W-1:0]
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   valid_in/ready_in      input word handshake; data_in, last_in with it
//   flush_in               close a non-empty partial phrase
//   valid_out/ready_out    output phrase handshake
//   data_out, keep_out     phrase and per-arrival-slot keep mask
//   last_out               phrase was closed by last_in
//
// Optional build macro PHRASE_PACKER_STATS_EN adds these two outputs:
//   phrase_count_out       output handshakes (wraps at 2^32)
//   stall_count_out        cycles with valid_in && !ready_in (wraps at 2^32)
module phrase_packer #(
  parameter int WORD_W       = 16,
  parameter int PHRASE_WORDS = 8,
  parameter int MSW_FIRST    = 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic [WORD_W-1:0]              data_in,
  input  logic                           last_in,
  input  logic                           flush_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [WORD_W*PHRASE_WORDS-1:0] data_out,
  output logic [PHRASE_WORDS-1:0]        keep_out,
  output logic                           last_out
`ifdef PHRASE_PACKER_STATS_EN
  ,
  output logic [31:0]                    phrase_count_out,
  output logic [31:0]                    stall_count_out
`endif
);

  localparam int IW = $clog2(PHRASE_WORDS);
  localparam int CW = IW + 1;
  localparam int PW = WORD_W * PHRASE_WORDS;

  logic [WORD_W-1:0] r_acc [PHRASE_WORDS];
  logic [CW-1:0]     r_count;
  logic              r_done;
  logic              r_last;

  logic              w_move;
  logic              w_accept;
  logic [CW-1:0]     w_base;
  logic [IW-1:0]     w_slot;
  logic              w_full;
  logic              w_flush_close;
  logic [PW-1:0]     w_phrase;
  logic [PHRASE_WORDS-1:0] w_keep;

  // The phrase in the accumulator moves out when the output register is
  // empty or is being drained in this same cycle.
  assign w_move   = r_done && (!valid_out || ready_out);
  assign ready_in = !r_done || w_move;
  assign w_accept = valid_in && ready_in;

  // On a move cycle the accumulator is emptied, so the incoming word goes
  // to slot 0 of the new phrase.
  assign w_base = w_move ? '0 : r_count;
  assign w_slot = w_base[IW-1:0];
  assign w_full = (w_base == CW'(PHRASE_WORDS - 1));

  // A flush with no word accepted closes only a pending partial phrase.
  assign w_flush_close = flush_in && !w_accept && !r_done && (r_count != '0);

  // Slot data needs no reset. The keep mask hides slots that were not written.
  always_ff @(posedge clk_in) begin
    if (w_accept) r_acc[w_slot] <= data_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= '0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_move) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_accept) begin
        r_count <= w_base + CW'(1);
        r_done  <= w_full || last_in || flush_in;
        r_last  <= last_in;
      end else if (w_flush_close) begin
        r_done  <= 1'b1;
      end
    end
  end

  // Place each arrival slot in data_out. Unfilled slots read zero.
  always_comb begin
    w_phrase = '0;
    w_keep   = '0;
    for (int i = 0; i < PHRASE_WORDS; i++) begin
      if (CW'(i) < r_count) begin
        w_keep[i] = 1'b1;
        if (MSW_FIRST != 0)
          w_phrase[(PHRASE_WORDS-1-i)*WORD_W +: WORD_W] = r_acc[i];
        else
          w_phrase[i*WORD_W +: WORD_W] = r_acc[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (w_move) begin
      valid_out <= 1'b1;
      data_out  <= w_phrase;
      keep_out  <= w_keep;
      last_out  <= r_last;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

`ifdef PHRASE_PACKER_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phrase_count_out <= '0;
      stall_count_out  <= '0;
    end else begin
      if (valid_out && ready_out) phrase_count_out <= phrase_count_out + 32'd1;
      if (valid_in && !ready_in)  stall_count_out  <= stall_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phrase_packer.sv
module tb_phrase_packer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic          valid_in = 1'b0, last_in = 1'b0, flush_in = 1'b0, ready_out = 1'b1;
  logic [15:0]   data_in = '0;
  logic          ready_in, valid_out, last_out;
  logic [127:0]  data_out;
  logic [7:0]    keep_out;

  // Byte-wide, 4-word, LS-first instance
  logic          v8 = 1'b0, l8 = 1'b0, f8 = 1'b0, ro8 = 1'b1;
  logic [7:0]    d8 = '0;
  logic          rin8, vo8, lo8;
  logic [31:0]   do8;
  logic [3:0]    k8;

`ifdef PHRASE_PACKER_STATS_EN
  logic [31:0]   pc, sc, pc8, sc8;
`endif

  phrase_packer u_dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .last_in(last_in), .flush_in(flush_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .keep_out(keep_out), .last_out(last_out)
`ifdef PHRASE_PACKER_STATS_EN
    , .phrase_count_out(pc), .stall_count_out(sc)
`endif
  );

  phrase_packer #(.WORD_W(8), .PHRASE_WORDS(4), .MSW_FIRST(0)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .valid_in(v8), .ready_in(rin8),
    .data_in(d8), .last_in(l8), .flush_in(f8),
    .valid_out(vo8), .ready_out(ro8), .data_out(do8),
    .keep_out(k8), .last_out(lo8)
`ifdef PHRASE_PACKER_STATS_EN
    , .phrase_count_out(pc8), .stall_count_out(sc8)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phrases are lists of accepted words
  typedef struct {
    logic [127:0] d;
    logic [7:0]   k;
    logic         l;
  } phrase_t;

  logic [15:0] cur[$];
  phrase_t     expq[$];

  function automatic void close_phrase(input logic l);
    phrase_t p;
    p.d = '0;
    p.k = '0;
    for (int i = 0; i < cur.size(); i++) begin
      p.d[(7-i)*16 +: 16] = cur[i];
      p.k[i] = 1'b1;
    end
    p.l = l;
    expq.push_back(p);
    cur.delete();
  endfunction

  logic         pv_stall = 1'b0;
  logic [136:0] prev_out;

  // Inputs change 1 time unit after posedge, so values seen at negedge are
  // the ones the next posedge will register.
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      expq.delete();
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) begin
        check("hold_valid", {127'd0, valid_out}, 128'd1);
        check("hold_out", {119'd0, data_out, keep_out, last_out}, {119'd0, prev_out});
      end
      pv_stall = valid_out && !ready_out;
      prev_out = {data_out, keep_out, last_out};
      if (valid_out && ready_out) begin
        if (expq.size() == 0) begin
          check("sb_extra_phrase", data_out, 128'hx);
        end else begin
          phrase_t e;
          e = expq.pop_front();
          check("sb_data", data_out, e.d);
          check("sb_keep", {120'd0, keep_out}, {120'd0, e.k});
          check("sb_last", {127'd0, last_out}, {127'd0, e.l});
        end
      end
      if (valid_in && ready_in) begin
        cur.push_back(data_in);
        if (cur.size() == 8 || last_in || flush_in) close_phrase(last_in);
      end else if (flush_in && cur.size() > 0) begin
        close_phrase(1'b0);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic f);
    @(posedge clk);
    #1;
    valid_in = v;
    data_in  = d;
    last_in  = l;
    flush_in = f;
  endtask

  typedef struct {
    logic         v;
    logic [15:0]  d;
    logic         l;
    logic         f;
    logic         e_vo;
    logic [127:0] e_do;
    logic [7:0]   e_k;
    logic         e_lo;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l, input logic f,
                              input logic evo, input logic [127:0] edo, input logic [7:0] ek,
                              input logic elo);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.f = f;
    r.e_vo = evo; r.e_do = edo; r.e_k = ek; r.e_lo = elo;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[19];
    int   first_low, k, cyc;

    tbl[0]  = mk(1, 16'h000A, 0, 0, 0, '0, '0, 0);
    tbl[1]  = mk(1, 16'h000B, 0, 0, 0, '0, '0, 0);
    tbl[2]  = mk(1, 16'h000C, 1, 0, 0, '0, '0, 0);
    tbl[3]  = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[4]  = mk(0, 16'h0000, 0, 0, 1, 128'h000A_000B_000C_0000_0000_0000_0000_0000, 8'h07, 1);
    tbl[5]  = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[6]  = mk(1, 16'h0101, 0, 0, 0, '0, '0, 0);
    tbl[7]  = mk(1, 16'h0102, 0, 0, 0, '0, '0, 0);
    tbl[8]  = mk(1, 16'h0103, 0, 0, 0, '0, '0, 0);
    tbl[9]  = mk(1, 16'h0104, 0, 0, 0, '0, '0, 0);
    tbl[10] = mk(1, 16'h0105, 0, 0, 0, '0, '0, 0);
    tbl[11] = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[12] = mk(0, 16'h0000, 0, 1, 0, '0, '0, 0);
    tbl[13] = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[14] = mk(0, 16'h0000, 0, 0, 1, 128'h0101_0102_0103_0104_0105_0000_0000_0000, 8'h1F, 0);
    tbl[15] = mk(0, 16'h0000, 0, 1, 0, '0, '0, 0);
    tbl[16] = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[17] = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);
    tbl[18] = mk(0, 16'h0000, 0, 0, 0, '0, '0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_out", {127'd0, valid_out}, 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_keep_out", {120'd0, keep_out}, 128'd0);
    check("rst_last_out", {127'd0, last_out}, 128'd0);
    check("rst_ready_in", {127'd0, ready_in}, 128'd1);

    // Streaming 16 words with ready_out high
    for (int i = 0; i < 16; i++) begin
      drive(1, 16'(i + 1), 0, 0);
      @(negedge clk);
      check("stream_ready_in", {127'd0, ready_in}, 128'd1);
      if (i == 9) begin
        check("stream_p1_valid", {127'd0, valid_out}, 128'd1);
        check("stream_p1_data", data_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        check("stream_p1_keep", {120'd0, keep_out}, 128'hFF);
        check("stream_p1_last", {127'd0, last_out}, 128'd0);
      end
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("stream_p2_valid", {127'd0, valid_out}, 128'd1);
    check("stream_p2_data", data_out, 128'h0009_000A_000B_000C_000D_000E_000F_0010);

    // Table: last_in close, flush close, flush on empty accumulator
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
      @(negedge clk);
      check($sformatf("tbl%0d_ready_in", i), {127'd0, ready_in}, 128'd1);
      check($sformatf("tbl%0d_valid_out", i), {127'd0, valid_out}, {127'd0, tbl[i].e_vo});
      if (tbl[i].e_vo) begin
        check($sformatf("tbl%0d_data", i), data_out, tbl[i].e_do);
        check($sformatf("tbl%0d_keep", i), {120'd0, keep_out}, {120'd0, tbl[i].e_k});
        check($sformatf("tbl%0d_last", i), {127'd0, last_out}, {127'd0, tbl[i].e_lo});
      end
    end

    // Backpressure: 24 words with ready_out low, released later
    first_low = 0;
    k = 1;
    cyc = 0;
    while (k <= 24 && cyc < 200) begin
      @(posedge clk);
      #1;
      ready_out = (cyc >= 30);
      valid_in  = 1'b1;
      data_in   = 16'(16'h0200 + k);
      last_in   = 1'b0;
      flush_in  = 1'b0;
      @(negedge clk);
      if (!ready_in && first_low == 0) first_low = k;
      if (ready_in) k++;
      cyc++;
    end
    check("bp_first_stalled_word", 128'(first_low), 128'd17);
    check("bp_all_accepted", 128'(k), 128'd25);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
    @(negedge clk);
    check("bp_drained", 128'(expq.size()), 128'd0);
    check("bp_no_partial", 128'(cur.size()), 128'd0);

    // Byte-wide LS-first instance
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      v8 = (i < 4);
      d8 = 8'(8'h11 * (i + 1));
      @(negedge clk);
      if (i == 5) begin
        check("b8_valid", {127'd0, vo8}, 128'd1);
        check("b8_data", {96'd0, do8}, 128'h44332211);
        check("b8_keep", {124'd0, k8}, 128'hF);
        check("b8_last", {127'd0, lo8}, 128'd0);
      end
    end
    @(posedge clk);
    #1 v8 = 1'b0;

    // Reset mid-phrase with a phrase held at the output
    ready_out = 1'b0;
    for (int i = 0; i < 12; i++) drive(1, 16'(16'h0300 + i), 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_valid_held", {127'd0, valid_out}, 128'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid_out", {127'd0, valid_out}, 128'd0);
    check("mid_rst_data_out", data_out, 128'd0);
    check("mid_rst_keep_out", {120'd0, keep_out}, 128'd0);
    check("mid_rst_last_out", {127'd0, last_out}, 128'd0);
`ifdef PHRASE_PACKER_STATS_EN
    check("mid_rst_phrase_count", {96'd0, pc}, 128'd0);
    check("mid_rst_stall_count", {96'd0, sc}, 128'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 16'(16'h0400 + i), 0, 0);
      @(negedge clk);
      if (i == 9) begin
        check("post_rst_valid", {127'd0, valid_out}, 128'd1);
        check("post_rst_data", data_out, 128'h0400_0401_0402_0403_0404_0405_0406_0407);
        check("post_rst_keep", {120'd0, keep_out}, 128'hFF);
      end
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      valid_in  = ($urandom_range(0, 3) != 0);
      data_in   = 16'($urandom);
      last_in   = ($urandom_range(0, 7) == 0);
      flush_in  = ($urandom_range(0, 9) == 0);
      ready_out = ($urandom_range(0, 2) != 0);
    end
    drive(0, 0, 0, 1);
    @(posedge clk);
    #1;
    flush_in  = 1'b0;
    ready_out = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rand_drained", 128'(expq.size()), 128'd0);
    check("rand_no_partial", 128'(cur.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
